oled_spi_driver: RTL and testbench

- Display-side engine for the 128x64 SSD1306 OLED over 4-wire SPI.
- After reset it pulses the panel reset line, then sends the fixed init command list.
- It then streams 1024-byte frames forever: drives byte_counter to the image/status-bar source and serialises the returned data_to_send bytes.
- Sits between the image controller and the board OLED pins.

---
 rtl/oled_pkg.sv | 29 ++
 rtl/oled_cmd_rom.sv | 46 ++++
 rtl/oled_spi_driver.sv | 151 +++++++++++++++
 tb/tb_oled_spi_driver.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: FSM states, command-list lengths and SSD1306 opcodes shared by the OLED SPI driver.
package oled_pkg;

    typedef enum logic [2:0] {RES_LOW, RES_HIGH, INIT, ADDR, DATA, GAP} state_t;
    typedef enum logic [2:0] {P_IDLE, P_SETUP, P_HI, P_LO, P_CSH} phase_t;

    localparam logic [4:0] INIT_LEN = 5'd25;
    localparam logic [4:0] ADDR_LEN = 5'd6;

    localparam logic [7:0] DISPLAY_OFF    = 8'hAE;
    localparam logic [7:0] DISPLAY_ON     = 8'hAF;
    localparam logic [7:0] SET_CLK_DIV    = 8'hD5;
    localparam logic [7:0] SET_MUX        = 8'hA8;
    localparam logic [7:0] SET_OFFSET     = 8'hD3;
    localparam logic [7:0] SET_START_LINE = 8'h40;
    localparam logic [7:0] CHARGE_PUMP    = 8'h8D;
    localparam logic [7:0] SET_MEM_MODE   = 8'h20;
    localparam logic [7:0] SEG_REMAP      = 8'hA1;
    localparam logic [7:0] COM_SCAN_DEC   = 8'hC8;
    localparam logic [7:0] SET_COM_PINS   = 8'hDA;
    localparam logic [7:0] SET_CONTRAST   = 8'h81;
    localparam logic [7:0] SET_PRECHARGE  = 8'hD9;
    localparam logic [7:0] SET_VCOM       = 8'hDB;
    localparam logic [7:0] RESUME_RAM     = 8'hA4;
    localparam logic [7:0] NORMAL_DISP    = 8'hA6;
    localparam logic [7:0] SET_COL        = 8'h21;
    localparam logic [7:0] SET_PAGE       = 8'h22;

endpackage

// File: rtl/oled_cmd_rom.sv
// oled_cmd_rom: SSD1306 init list (entries 0-24) followed by the full-window address list (25-30).
module oled_cmd_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] data
);

    always_comb begin
        case (idx)
            5'd0:    data = DISPLAY_OFF;
            5'd1:    data = SET_CLK_DIV;
            5'd2:    data = 8'h80;
            5'd3:    data = SET_MUX;
            5'd4:    data = 8'h3F;
            5'd5:    data = SET_OFFSET;
            5'd6:    data = 8'h00;
            5'd7:    data = SET_START_LINE;
            5'd8:    data = CHARGE_PUMP;
            5'd9:    data = 8'h14;
            5'd10:   data = SET_MEM_MODE;
            5'd11:   data = 8'h00;
            5'd12:   data = SEG_REMAP;
            5'd13:   data = COM_SCAN_DEC;
            5'd14:   data = SET_COM_PINS;
            5'd15:   data = 8'h12;
            5'd16:   data = SET_CONTRAST;
            5'd17:   data = 8'hCF;
            5'd18:   data = SET_PRECHARGE;
            5'd19:   data = 8'hF1;
            5'd20:   data = SET_VCOM;
            5'd21:   data = 8'h40;
            5'd22:   data = RESUME_RAM;
            5'd23:   data = NORMAL_DISP;
            5'd24:   data = DISPLAY_ON;
            5'd25:   data = SET_COL;
            5'd26:   data = 8'h00;
            5'd27:   data = 8'h7F;
            5'd28:   data = SET_PAGE;
            5'd29:   data = 8'h00;
            5'd30:   data = 8'h07;
            default: data = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_spi_driver.sv
// oled_spi_driver: SSD1306 128x64 panel reset, init command list and continuous 4-wire SPI frame streaming.
// Define OLED_FRAME_SYNC_EN to add frame_req and hold each inter-frame gap until a request arrives.
module oled_spi_driver
    import oled_pkg::*;
#(
    parameter int          CLK_DIV     = 4,
    parameter logic [15:0] RES_CYCLES  = 16'd50000,
    parameter int          FRAME_BYTES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_to_send,
`ifdef OLED_FRAME_SYNC_EN
    input  logic       frame_req,
`endif
    output logic [9:0] byte_counter,
    output logic       oled_sclk,
    output logic       oled_mosi,
    output logic       oled_cs,
    output logic       oled_dc,
    output logic       oled_res,
    output logic       frame_done
);

    localparam int          DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [9:0]  LAST     = 10'(FRAME_BYTES - 1);
    localparam logic [4:0]  ADDR_END = INIT_LEN + ADDR_LEN;

    state_t        state;
    phase_t        ph;
    logic [15:0]   timer;
    logic [DW-1:0] div;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic [4:0]    idx;
    logic          sent_last;
    logic [7:0]    rom_byte;
    logic [7:0]    load_byte;
    logic          tick, timer_done, load, go;

    oled_cmd_rom u_rom (.idx(idx), .data(rom_byte));

    assign tick       = div == DIV_MAX;
    assign timer_done = timer >= RES_CYCLES - 16'd1;
    assign load_byte  = state == DATA ? data_to_send : rom_byte;
    assign load       = ph == P_IDLE && ((state == INIT && idx != INIT_LEN) ||
                                         (state == ADDR && idx != ADDR_END) ||
                                         (state == DATA && !sent_last));

`ifdef OLED_FRAME_SYNC_EN
    logic req_seen;
    assign go = frame_req | req_seen;
`else
    assign go = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RES_LOW;
            ph           <= P_IDLE;
            timer        <= '0;
            div          <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            idx          <= '0;
            sent_last    <= 1'b0;
            byte_counter <= '0;
            oled_sclk    <= 1'b0;
            oled_mosi    <= 1'b0;
            oled_cs      <= 1'b1;
            oled_dc      <= 1'b0;
            oled_res     <= 1'b0;
            frame_done   <= 1'b0;
`ifdef OLED_FRAME_SYNC_EN
            req_seen     <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            div        <= tick ? '0 : div + 1'b1;
`ifdef OLED_FRAME_SYNC_EN
            if (frame_req) req_seen <= 1'b1;
            if (state == GAP && go) req_seen <= 1'b0;
`endif
            case (state)
                RES_LOW, RES_HIGH: begin
                    timer <= timer_done ? '0 : timer + 16'd1;
                    if (timer_done) begin
                        state    <= state == RES_LOW ? RES_HIGH : INIT;
                        oled_res <= 1'b1;
                    end
                end
                INIT, ADDR: begin
                    if (load) idx <= idx + 5'd1;
                    else if (ph == P_IDLE) state <= state == INIT ? ADDR : DATA;
                end
                DATA: begin
                    // byte_counter pre-fetches the next byte but parks on the last index
                    if (load) begin
                        byte_counter <= byte_counter == LAST ? byte_counter : byte_counter + 10'd1;
                        sent_last    <= byte_counter == LAST;
                    end else if (ph == P_IDLE) begin
                        state      <= GAP;
                        frame_done <= 1'b1;
                    end
                end
                GAP: begin
                    byte_counter <= '0;
                    sent_last    <= 1'b0;
                    idx          <= INIT_LEN;
                    if (go) state <= ADDR;
                end
                default: state <= RES_LOW;
            endcase
            case (ph)
                P_IDLE: if (load) begin
                    ph        <= P_SETUP;
                    oled_cs   <= 1'b0;
                    oled_dc   <= state == DATA;
                    oled_mosi <= load_byte[7];
                    shreg     <= load_byte[6:0];
                    div       <= '0;
                end
                P_SETUP: if (tick) begin
                    oled_sclk <= 1'b1;
                    ph        <= P_HI;
                end
                P_HI: if (tick) begin
                    oled_sclk <= 1'b0;
                    oled_mosi <= shreg[6];
                    shreg     <= {shreg[5:0], 1'b0};
                    bit_cnt   <= bit_cnt + 3'd1;
                    ph        <= P_LO;
                end
                // the low half after the 8th fall is the cs hold time before release
                P_LO: if (tick) begin
                    if (bit_cnt == 3'd0) begin
                        oled_cs <= 1'b1;
                        ph      <= P_CSH;
                    end else begin
                        oled_sclk <= 1'b1;
                        ph        <= P_HI;
                    end
                end
                P_CSH: if (tick) ph <= P_IDLE;
                default: ph <= P_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_driver.sv
// tb_oled_spi_driver: random frame data streamed through oled_spi_driver, decoded by an SPI slave
// and compared against the expected command/data byte stream.
`timescale 1ns/1ps
module tb_oled_spi_driver;

    localparam int CLK_DIV = 2;
    localparam int RES     = 8;
    localparam int NB      = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_to_send = 8'h00;
    logic [9:0] byte_counter;
    logic       oled_sclk, oled_mosi, oled_cs, oled_dc, oled_res, frame_done;

    int checks = 0;
    int failures = 0;
    int fd_clks = 0;

    logic [7:0] mem [NB];
    logic [8:0] rx_q [$];
    logic [7:0] init_ref [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                                  8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
                                  8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] addr_ref [6]  = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    oled_spi_driver #(.CLK_DIV(CLK_DIV), .RES_CYCLES(16'(RES)), .FRAME_BYTES(NB)) dut (
        .clk(clk), .rst(rst), .data_to_send(data_to_send), .byte_counter(byte_counter),
        .oled_sclk(oled_sclk), .oled_mosi(oled_mosi), .oled_cs(oled_cs), .oled_dc(oled_dc),
        .oled_res(oled_res), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // image source: registered lookup, valid one clk after byte_counter changes
    always_ff @(posedge clk) data_to_send <= mem[byte_counter];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic get_byte(input string tag, input logic [8:0] exp);
        int n = 0;
        while (rx_q.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'(rx_q.size()), 1);
            done();
        end else chk(tag, 32'(rx_q.pop_front()), 32'(exp));
    endtask

    task automatic res_seq(input string tag);
        int n = 0;
        int bad = 0;
        while (!oled_res && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!oled_cs) bad++;
        end
        chk({tag, "_res_low_clks"}, n, RES);
        n = 0;
        while (oled_cs && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!oled_res) bad++;
        end
        chk({tag, "_res_high_then_cs"}, 32'(n >= RES && n <= RES + 2), 1);
        chk({tag, "_cs_idle_during_reset"}, bad, 0);
    endtask

    // SPI slave and protocol timing monitor, sampled mid-cycle
    logic       p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0, p_mosi = 1'b0;
    logic [9:0] p_bc = '0;
    logic [7:0] sh = '0;
    int run = 0, hi_run = 0, nbits = 0;

    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
            run = 0;
            hi_run = 0;
        end else begin
            if (oled_sclk && !p_sclk) begin
                chk("sclk_low_half", run, CLK_DIV);
                chk("mosi_stable_at_rise", oled_mosi, p_mosi);
                sh = {sh[6:0], oled_mosi};
                nbits++;
                if (nbits == 8) begin
                    rx_q.push_back({oled_dc, sh});
                    nbits = 0;
                end
            end
            if (!oled_sclk && p_sclk) chk("sclk_high_half", run, CLK_DIV);
            if (oled_cs && !p_cs) chk("cs_rise_after_fall", run, CLK_DIV);
            if (!oled_cs && p_cs) begin
                chk("cs_high_gap", 32'(hi_run >= CLK_DIV), 1);
                nbits = 0;
            end
            if (!oled_cs && !p_cs) chk("dc_stable_cs_low", oled_dc, p_dc);
            if (byte_counter != p_bc)
                chk("byte_counter_step", 32'(({1'b0, byte_counter} == {1'b0, p_bc} + 11'd1) ||
                                             (byte_counter == 10'd0 && p_bc == 10'(NB - 1))), 1);
            run = (oled_sclk != p_sclk || oled_cs != p_cs) ? 1 : run + 1;
            hi_run = oled_cs ? hi_run + 1 : 0;
            if (frame_done) fd_clks++;
        end
        p_sclk = oled_sclk;
        p_cs   = oled_cs;
        p_dc   = oled_dc;
        p_mosi = oled_mosi;
        p_bc   = byte_counter;
    end

    initial begin
        int n;
        foreach (mem[i]) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("rst_sclk", oled_sclk, 0);
        chk("rst_mosi", oled_mosi, 0);
        chk("rst_cs", oled_cs, 1);
        chk("rst_dc", oled_dc, 0);
        chk("rst_res", oled_res, 0);
        chk("rst_byte_counter", byte_counter, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        res_seq("boot");
        for (int i = 0; i < 25; i++) get_byte("init", {1'b0, init_ref[i]});
        for (int i = 0; i < 6; i++) get_byte("addr", {1'b0, addr_ref[i]});
        for (int i = 0; i < NB; i++) get_byte("data", {1'b1, mem[i]});
        chk("frame_done_not_early", fd_clks, 0);
        for (int i = 0; i < 6; i++) get_byte("addr_next", {1'b0, addr_ref[i]});
        chk("frame_done_one_pulse", fd_clks, 1);
        n = 0;
        while (byte_counter != 10'd501 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_byte_500", byte_counter, 501);
        repeat (7) @(negedge clk);
        chk("mid_byte_cs_low", oled_cs, 0);
        rst = 1'b1;
        #1;
        chk("async_sclk", oled_sclk, 0);
        chk("async_mosi", oled_mosi, 0);
        chk("async_cs", oled_cs, 1);
        chk("async_dc", oled_dc, 0);
        chk("async_res", oled_res, 0);
        chk("async_byte_counter", byte_counter, 0);
        chk("async_frame_done", frame_done, 0);
        rx_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        res_seq("reboot");
        for (int i = 0; i < 25; i++) get_byte("reinit", {1'b0, init_ref[i]});
        for (int i = 0; i < 6; i++) get_byte("readdr", {1'b0, addr_ref[i]});
        done();
    end

endmodule
